// File: rtl/amp_bias_ctrl.sv
// Amplifier bias calibration controller: powers the amplifier, settles, averages
// four ADC amplitude samples and steps the bias trim DAC until the gain is in window.
module amp_bias_ctrl #(
   parameter int unsigned SETTLE_CYC = 64,
   parameter int unsigned ADC_W      = 12,
   parameter int unsigned TRIM_W     = 6,
   parameter int unsigned TRIM_INIT  = 32,
   parameter int unsigned GAIN_LO    = 1800,
   parameter int unsigned GAIN_HI    = 2200,
   parameter int unsigned MAX_STEPS  = 40
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   output logic              adc_req,
   input  logic              adc_ack,
   input  logic [ADC_W-1:0]  adc_data,
   output logic              vcc_en,
   output logic [TRIM_W-1:0] bias_trim,
   output logic              busy,
   output logic              locked,
   output logic              fault
);

   localparam int unsigned ACC_W  = ADC_W + 2;
   localparam int unsigned SET_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam int unsigned STEP_W = (MAX_STEPS > 0) ? $clog2(MAX_STEPS + 1) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_MEAS,
      ST_EVAL,
      ST_LOCKED,
      ST_FAULT
   } state_e;

   state_e              state_q, state_d;
   logic [SET_W-1:0]    settle_cnt_q, settle_cnt_d;
   logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
   logic [1:0]          samp_idx_q, samp_idx_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [TRIM_W-1:0]   trim_q, trim_d;
   logic                req_q, req_d;
   logic                vcc_q, vcc_d;
   logic                busy_q, busy_d;
   logic                locked_q, locked_d;
   logic                fault_q, fault_d;

   logic [ADC_W-1:0]    avg;
   logic                need_up;
   logic                need_dn;
   logic                cant_adjust;

   // Average of four samples and the trim decision taken in EVAL
   assign avg         = acc_q[ACC_W-1:2];
   assign need_up     = (avg < ADC_W'(GAIN_LO));
   assign need_dn     = (avg > ADC_W'(GAIN_HI));
   assign cant_adjust = (step_cnt_q == STEP_W'(MAX_STEPS)) ||
                        (need_up && (trim_q == '1)) ||
                        (need_dn && (trim_q == '0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         settle_cnt_q <= '0;
         step_cnt_q   <= '0;
         samp_idx_q   <= '0;
         acc_q        <= '0;
         trim_q       <= TRIM_W'(TRIM_INIT);
         req_q        <= 1'b0;
         vcc_q        <= 1'b0;
         busy_q       <= 1'b0;
         locked_q     <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         settle_cnt_q <= settle_cnt_d;
         step_cnt_q   <= step_cnt_d;
         samp_idx_q   <= samp_idx_d;
         acc_q        <= acc_d;
         trim_q       <= trim_d;
         req_q        <= req_d;
         vcc_q        <= vcc_d;
         busy_q       <= busy_d;
         locked_q     <= locked_d;
         fault_q      <= fault_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      settle_cnt_d = settle_cnt_q;
      step_cnt_d   = step_cnt_q;
      samp_idx_d   = samp_idx_q;
      acc_d        = acc_q;
      trim_d       = trim_q;
      req_d        = req_q;
      vcc_d        = vcc_q;
      busy_d       = busy_q;
      locked_d     = locked_q;
      fault_d      = fault_q;

      case (state_q)
         ST_IDLE, ST_LOCKED, ST_FAULT: begin
            if (start) begin
               state_d      = ST_SETTLE;
               vcc_d        = 1'b1;
               trim_d       = TRIM_W'(TRIM_INIT);
               step_cnt_d   = '0;
               settle_cnt_d = '0;
               locked_d     = 1'b0;
               fault_d      = 1'b0;
               busy_d       = 1'b1;
            end
         end
         ST_SETTLE: begin
            if (settle_cnt_q == SET_W'(SETTLE_CYC - 1)) begin
               state_d    = ST_MEAS;
               samp_idx_d = '0;
               acc_d      = '0;
               req_d      = 1'b1;
            end else begin
               settle_cnt_d = settle_cnt_q + SET_W'(1);
            end
         end
         ST_MEAS: begin
            // Request drops for one cycle after every accepted sample
            if (req_q) begin
               if (adc_ack) begin
                  acc_d      = acc_q + ACC_W'(adc_data);
                  samp_idx_d = samp_idx_q + 2'd1;
                  req_d      = 1'b0;
                  if (samp_idx_q == 2'd3) begin
                     state_d = ST_EVAL;
                  end
               end
            end else begin
               req_d = 1'b1;
            end
         end
         ST_EVAL: begin
            if (!need_up && !need_dn) begin
               state_d  = ST_LOCKED;
               locked_d = 1'b1;
               busy_d   = 1'b0;
            end else if (cant_adjust) begin
               state_d = ST_FAULT;
               fault_d = 1'b1;
               vcc_d   = 1'b0;
               busy_d  = 1'b0;
            end else begin
               state_d      = ST_SETTLE;
               trim_d       = need_up ? (trim_q + TRIM_W'(1)) : (trim_q - TRIM_W'(1));
               step_cnt_d   = step_cnt_q + STEP_W'(1);
               settle_cnt_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Abort overrides everything above, including a same-cycle sample
      if (abort && (state_q != ST_IDLE)) begin
         state_d      = ST_IDLE;
         settle_cnt_d = settle_cnt_q;
         step_cnt_d   = step_cnt_q;
         samp_idx_d   = samp_idx_q;
         acc_d        = acc_q;
         trim_d       = trim_q;
         req_d        = 1'b0;
         vcc_d        = 1'b0;
         busy_d       = 1'b0;
         locked_d     = 1'b0;
         fault_d      = 1'b0;
      end
   end

   assign adc_req   = req_q;
   assign vcc_en    = vcc_q;
   assign bias_trim = trim_q;
   assign busy      = busy_q;
   assign locked    = locked_q;
   assign fault     = fault_q;

endmodule

// File: doc/amp_bias_ctrl.md
AMP_BIAS_CTRL -- requirements
Module: amp_bias_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 64: cycles waited after power-up or any trim change before measuring (SETTLE_CYC >= 1).
REQ-002 SHALL have parameter ADC_W, default 12: ADC sample width.
REQ-003 SHALL have parameter TRIM_W, default 6: bias trim DAC code width.
REQ-004 SHALL have parameter TRIM_INIT, default 32: trim code loaded at reset and on each accepted start.
REQ-005 SHALL have parameter GAIN_LO, default 1800: lower bound, inclusive, of the accepted averaged sample.
REQ-006 SHALL have parameter GAIN_HI, default 2200: upper bound, inclusive, of the accepted averaged sample.
REQ-007 SHALL have parameter MAX_STEPS, default 40: trim adjustments allowed before fault.
REQ-008 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-009 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-010 SHALL have port start, input, 1 bit: begin calibration; sampled each cycle.
REQ-011 SHALL have port abort, input, 1 bit: cancel calibration and power down.
REQ-012 SHALL have port adc_req, output, 1 bit: registered request for one output-level sample.
REQ-013 SHALL have port adc_ack, input, 1 bit: sample valid on adc_data.
REQ-014 SHALL have port adc_data, input, ADC_W bits: unsigned amplifier output amplitude sample.
REQ-015 SHALL have port vcc_en, output, 1 bit: amplifier supply enable.
REQ-016 SHALL have port bias_trim, output, TRIM_W bits: bias current DAC code.
REQ-017 SHALL have port busy, output, 1 bit: high in SETTLE, MEAS and EVAL.
REQ-018 SHALL have port locked, output, 1 bit: calibration succeeded.
REQ-019 SHALL have port fault, output, 1 bit: calibration failed.

Function
REQ-020 SHALL implement states IDLE, SETTLE, MEAS, EVAL, LOCKED and FAULT.
REQ-021 IDLE, LOCKED or FAULT with start=1 SHALL move to SETTLE next cycle: vcc_en=1, bias_trim=TRIM_INIT, step count 0, settle count 0, locked=0, fault=0.
REQ-022 start SHALL be ignored while busy=1.
REQ-023 SETTLE SHALL last exactly SETTLE_CYC cycles, then enter MEAS with sample index 0 and accumulator 0.
REQ-024 MEAS: adc_req SHALL rise on the first MEAS cycle and hold until adc_ack=1 is sampled.
REQ-025 MEAS: on the ack cycle adc_data SHALL add to an (ADC_W+2)-bit accumulator; adc_req SHALL then be low for at least one cycle before the next request.
REQ-026 MEAS: after the 4th accepted sample the FSM SHALL enter EVAL; adc_ack while adc_req=0 SHALL be ignored.
REQ-027 EVAL SHALL last one cycle and compute avg = accumulator >> 2 (truncating).
REQ-028 EVAL: GAIN_LO <= avg <= GAIN_HI SHALL give LOCKED; locked=1, vcc_en=1, trim held.
REQ-029 EVAL: avg < GAIN_LO SHALL increment bias_trim; avg > GAIN_HI SHALL decrement it; step count +1; return to SETTLE.
REQ-030 EVAL: if an adjustment is needed and step count == MAX_STEPS, or the trim would leave 0..2^TRIM_W-1, the FSM SHALL go to FAULT with bias_trim unchanged.
REQ-031 FAULT SHALL give fault=1 and vcc_en=0, hold bias_trim for diagnostics, and keep adc_req=0.
REQ-032 abort=1 in any non-IDLE state SHALL give IDLE next cycle: vcc_en=0, adc_req=0, locked=0, fault=0, bias_trim held.
REQ-033 abort SHALL take priority over start and over an adc_ack in the same cycle; that sample SHALL be discarded.

Reset
REQ-034 rst_n=0 SHALL immediately force IDLE: adc_req=0, vcc_en=0, busy=0, locked=0, fault=0, bias_trim=TRIM_INIT, all counters and the accumulator 0, including mid-operation.
REQ-035 After rst_n deasserts, the first state change SHALL occur on the first rising clk edge with start=1.

Verification
REQ-036 Reset pulse mid-MEAS, defaults -> same cycle: adc_req=0, vcc_en=0, busy=0, bias_trim=32.
REQ-037 start; ADC returns 2000 x4 -> locked=1, bias_trim=32, vcc_en=1; exactly 4 adc_req pulses; first adc_req 65 cycles after start.
REQ-038 start; round 1 samples 1799,1800,1800,1800 (avg 1799), round 2 samples 2000 x4 -> bias_trim=33, then locked=1.
REQ-039 MAX_STEPS=5; ADC always 0 -> trim steps 33..37; 6th EVAL gives fault=1, vcc_en=0, bias_trim=37.
REQ-040 ADC always 4095 -> trim decrements to 0; next EVAL gives fault=1, bias_trim=0 (no wrap to 63).
REQ-041 abort and adc_ack asserted together in the 2nd MEAS round -> IDLE next cycle, adc_req=0, vcc_en=0, bias_trim held; new start reloads 32.
